mem_lsu: RTL

Load/store unit for the MEM stage of the 5-stage RV64 core. It consumes the memory-control fields delivered by the EX/MEM pipeline register and drives a single outstanding request on the data-memory bus using a valid/ready request channel and a valid response channel. It handles byte-lane alignment, write masks and load sign/zero extension. While an access is in flight it holds the pipeline with `stall_req`.

---
 rtl/mem_lsu_pkg.sv | 55 +++++
 rtl/mem_lsu_align.sv | 66 ++++++
 rtl/mem_lsu.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared opcodes, state encodings and size helpers for the load/store unit
package mem_lsu_pkg;

  // Load opcodes carried on memrop
  localparam logic [2:0] ROP_MNO = 3'd0;
  localparam logic [2:0] ROP_LB  = 3'd1;
  localparam logic [2:0] ROP_LH  = 3'd2;
  localparam logic [2:0] ROP_LW  = 3'd3;
  localparam logic [2:0] ROP_LD  = 3'd4;
  localparam logic [2:0] ROP_LBU = 3'd5;
  localparam logic [2:0] ROP_LHU = 3'd6;
  localparam logic [2:0] ROP_LWU = 3'd7;

  // Store opcodes carried on memwop
  localparam logic [2:0] WOP_MNO = 3'd0;
  localparam logic [2:0] WOP_SB  = 3'd1;
  localparam logic [2:0] WOP_SH  = 3'd2;
  localparam logic [2:0] WOP_SW  = 3'd3;
  localparam logic [2:0] WOP_SD  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10,
    ST_DONE = 2'b11
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } acc_size_e;

  // MNO and any unlisted store code fall back to a byte access
  function automatic acc_size_e wop_size(input logic [2:0] op);
    case (op)
      WOP_SH:  return SZ_H;
      WOP_SW:  return SZ_W;
      WOP_SD:  return SZ_D;
      default: return SZ_B;
    endcase
  endfunction

  // MNO loads are sized as bytes so they can never be flagged misaligned
  function automatic acc_size_e rop_size(input logic [2:0] op);
    case (op)
      ROP_LH, ROP_LHU: return SZ_H;
      ROP_LW, ROP_LWU: return SZ_W;
      ROP_LD:          return SZ_D;
      default:         return SZ_B;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// rtl/mem_lsu_align.sv - combinational lane alignment, mask generation and load extension
module mem_lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic              wr,
  input  logic [2:0]        memwop,
  input  logic [2:0]        memrop,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] stor_data,
  output logic [ADDR_W-1:0] aligned_addr,
  output logic [DATA_W-1:0] wdata,
  output logic [7:0]        wmask,
  output logic              misalign,
  input  logic [2:0]        ld_op,
  input  logic [2:0]        ld_off,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] ld_result
);

  acc_size_e         size;
  logic [2:0]        off;
  logic [DATA_W-1:0] shifted;

  // Request side: size the access, check alignment and place store data in its lanes
  always_comb begin
    off          = addr[2:0];
    size         = wr ? wop_size(memwop) : rop_size(memrop);
    aligned_addr = {addr[ADDR_W-1:3], 3'b000};
    misalign     = 1'b0;
    wdata        = '0;
    wmask        = 8'h00;
    case (size)
      SZ_H:    misalign = off[0];
      SZ_W:    misalign = |off[1:0];
      SZ_D:    misalign = |off;
      default: misalign = 1'b0;
    endcase
    if (wr) begin
      wdata = stor_data << {off, 3'b000};
      case (size)
        SZ_H:    wmask = 8'h03 << off;
        SZ_W:    wmask = 8'h0F << off;
        SZ_D:    wmask = 8'hFF;
        default: wmask = 8'h01 << off;
      endcase
    end
  end

  // Response side: bring the addressed bytes down to bit 0 and extend per the latched load op
  always_comb begin
    shifted = rdata >> {ld_off, 3'b000};
    case (ld_op)
      ROP_LB:  ld_result = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      ROP_LH:  ld_result = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      ROP_LW:  ld_result = {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
      ROP_LBU: ld_result = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      ROP_LHU: ld_result = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      ROP_LWU: ld_result = {{(DATA_W-32){1'b0}}, shifted[31:0]};
      default: ld_result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit with a single outstanding data-memory request
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_ena,
  input  logic              mem_wr,
  input  logic [2:0]        memwop,
  input  logic [2:0]        memrop,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_stor_data,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_wr,
  output logic [ADDR_W-1:0] dmem_req_addr,
  output logic [DATA_W-1:0] dmem_req_wdata,
  output logic [7:0]        dmem_req_wmask,
  input  logic              dmem_rsp_valid,
  input  logic [DATA_W-1:0] dmem_rsp_rdata,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_valid,
  output logic              misalign,
  output logic              stall_req
);

  lsu_state_e        state;
  logic [2:0]        ld_op_q;
  logic [2:0]        ld_off_q;
  logic              is_load_q;

  logic [ADDR_W-1:0] al_addr;
  logic [DATA_W-1:0] al_wdata;
  logic [7:0]        al_wmask;
  logic              al_misalign;
  logic [DATA_W-1:0] al_ld_result;

  mem_lsu_align #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_align (
    .wr          (mem_wr),
    .memwop      (memwop),
    .memrop      (memrop),
    .addr        (mem_addr),
    .stor_data   (mem_stor_data),
    .aligned_addr(al_addr),
    .wdata       (al_wdata),
    .wmask       (al_wmask),
    .misalign    (al_misalign),
    .ld_op       (ld_op_q),
    .ld_off      (ld_off_q),
    .rdata       (dmem_rsp_rdata),
    .ld_result   (al_ld_result)
  );

  // Hold the pipeline from the moment an access is seen until the bus transaction completes
  assign stall_req = ((state == ST_IDLE) && mem_ena) || (state == ST_REQ) || (state == ST_RESP);

  // Access sequencer: latch the access, drive the request, wait for the response, report
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      ld_op_q        <= ROP_MNO;
      ld_off_q       <= 3'd0;
      is_load_q      <= 1'b0;
      dmem_req_valid <= 1'b0;
      dmem_req_wr    <= 1'b0;
      dmem_req_addr  <= '0;
      dmem_req_wdata <= '0;
      dmem_req_wmask <= 8'h00;
      ld_data        <= '0;
      ld_valid       <= 1'b0;
      misalign       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ld_valid <= 1'b0;
          misalign <= 1'b0;
          if (mem_ena) begin
            ld_op_q   <= memrop;
            ld_off_q  <= mem_addr[2:0];
            is_load_q <= !mem_wr;
            if (al_misalign) begin
              // Skip the bus entirely and report the fault in the DONE cycle
              misalign <= 1'b1;
              state    <= ST_DONE;
            end else begin
              dmem_req_valid <= 1'b1;
              dmem_req_wr    <= mem_wr;
              dmem_req_addr  <= al_addr;
              dmem_req_wdata <= al_wdata;
              dmem_req_wmask <= al_wmask;
              state          <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            state          <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (dmem_rsp_valid) begin
            if (is_load_q) begin
              ld_data  <= al_ld_result;
              ld_valid <= 1'b1;
            end
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // The finished instruction is still in EX/MEM, so mem_ena is ignored here
          ld_valid <= 1'b0;
          misalign <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
